// File: rtl/fp_weight_loader.sv
// Host-side weight loader: packs 32-bit beats into 4x256-bit rows, writes them to the weight
// buffers with a toggle strobe, then sequences the read phase. Optional macro: FP_WLOAD_CHECKSUM_EN.
module fp_weight_loader #(
  parameter int unsigned BEAT_W = 32,
  parameter int unsigned WORD_W = 256,
  parameter int unsigned LANES  = 4,
  parameter int unsigned DEPTH  = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [BEAT_W-1:0] s_data,
  input  logic              start,
  input  logic              reload,
  output logic [WORD_W-1:0] weight_in0,
  output logic [WORD_W-1:0] weight_in1,
  output logic [WORD_W-1:0] weight_in2,
  output logic [WORD_W-1:0] weight_in3,
  output logic              is_new_weight,
  output logic              reset_pp,
  output logic              read_enable,
  output logic [6:0]        rows_loaded,
  output logic              busy,
  output logic              done,
  output logic              err_start,
  output logic [BEAT_W-1:0] checksum
);

  localparam int unsigned SlotsPerLane = WORD_W / BEAT_W;
  localparam int unsigned BeatsPerRow  = SlotsPerLane * LANES;
  localparam int unsigned SlotW        = $clog2(SlotsPerLane);
  localparam int unsigned LaneW        = $clog2(LANES);
  localparam int unsigned BeatW        = SlotW + LaneW;
  localparam int unsigned RunW         = $clog2(DEPTH);

  typedef enum logic [2:0] {
    StLoad,
    StHold,
    StLoaded,
    StPrime,
    StRun
  } state_e;

  state_e                                      state_q, state_d;
  logic [BeatW-1:0]                            beat_cnt_q, beat_cnt_d;
  logic [RunW-1:0]                             run_cnt_q, run_cnt_d;
  logic [LANES-1:0][SlotsPerLane-1:0][BEAT_W-1:0] lanes_q, lanes_d;
  logic                                        tog_q, tog_d;
  logic [6:0]                                  rows_q, rows_d;
  logic                                        s_ready_q, s_ready_d;
  logic                                        busy_q, busy_d;
  logic                                        reset_pp_q, reset_pp_d;
  logic                                        read_enable_q, read_enable_d;
  logic                                        done_q, done_d;
  logic                                        err_start_q, err_start_d;

  logic             beat_ok;
  logic [LaneW-1:0] lane_idx;
  logic [SlotW-1:0] slot_idx;

  assign beat_ok              = s_valid & s_ready_q;
  assign {lane_idx, slot_idx} = beat_cnt_q;

  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    run_cnt_d  = run_cnt_q;
    lanes_d    = lanes_q;
    tog_d      = tog_q;
    rows_d     = rows_q;
    done_d     = 1'b0;
    err_start_d = start && (state_q != StLoaded);

    unique case (state_q)
      StLoad: begin
        if (beat_ok) begin
          lanes_d[lane_idx][slot_idx] = s_data;
          if (beat_cnt_q == BeatW'(BeatsPerRow - 1)) begin
            beat_cnt_d = '0;
            tog_d      = ~tog_q;
            rows_d     = rows_q + 7'd1;
            state_d    = StHold;
          end else begin
            beat_cnt_d = beat_cnt_q + 1'b1;
          end
        end
      end
      // One stall cycle so the buffer samples the row while the lane regs are stable.
      StHold: state_d = (rows_q == 7'(DEPTH)) ? StLoaded : StLoad;
      StLoaded: begin
        if (start) begin
          state_d = StPrime;
        end else if (reload) begin
          state_d = StLoad;
          rows_d  = '0;
        end
      end
      StPrime: begin
        state_d   = StRun;
        run_cnt_d = '0;
      end
      StRun: begin
        if (run_cnt_q == RunW'(DEPTH - 1)) begin
          state_d = StLoaded;
          done_d  = 1'b1;
        end else begin
          run_cnt_d = run_cnt_q + 1'b1;
        end
      end
      default: state_d = StLoad;
    endcase

    // Outputs are registered: derive them from the next state.
    s_ready_d     = (state_d == StLoad);
    busy_d        = (state_d == StHold) || (state_d == StPrime) || (state_d == StRun);
    reset_pp_d    = (state_d == StPrime);
    read_enable_d = (state_d == StRun);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StLoad;
      beat_cnt_q    <= '0;
      run_cnt_q     <= '0;
      lanes_q       <= '0;
      tog_q         <= 1'b0;
      rows_q        <= '0;
      s_ready_q     <= 1'b1;
      busy_q        <= 1'b0;
      reset_pp_q    <= 1'b0;
      read_enable_q <= 1'b0;
      done_q        <= 1'b0;
      err_start_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      beat_cnt_q    <= beat_cnt_d;
      run_cnt_q     <= run_cnt_d;
      lanes_q       <= lanes_d;
      tog_q         <= tog_d;
      rows_q        <= rows_d;
      s_ready_q     <= s_ready_d;
      busy_q        <= busy_d;
      reset_pp_q    <= reset_pp_d;
      read_enable_q <= read_enable_d;
      done_q        <= done_d;
      err_start_q   <= err_start_d;
    end
  end

`ifdef FP_WLOAD_CHECKSUM_EN
  logic [BEAT_W-1:0] checksum_q, checksum_d;

  always_comb begin
    checksum_d = checksum_q;
    if (beat_ok) checksum_d = checksum_q ^ s_data;
  end

  // Survives reload; only reset clears it.
  always_ff @(posedge clk) begin
    if (reset) checksum_q <= '0;
    else       checksum_q <= checksum_d;
  end

  assign checksum = checksum_q;
`else
  assign checksum = '0;
`endif

  assign weight_in0    = lanes_q[0];
  assign weight_in1    = lanes_q[1];
  assign weight_in2    = lanes_q[2];
  assign weight_in3    = lanes_q[3];
  assign is_new_weight = tog_q;
  assign rows_loaded   = rows_q;
  assign s_ready       = s_ready_q;
  assign busy          = busy_q;
  assign reset_pp      = reset_pp_q;
  assign read_enable   = read_enable_q;
  assign done          = done_q;
  assign err_start     = err_start_q;

endmodule

// File: tb/tb_fp_weight_loader.sv
// Directed bench for fp_weight_loader with a toggle-write weight buffer model.
module tb_fp_weight_loader;

  logic         clk = 1'b0;
  logic         reset, s_valid, start, reload;
  logic [31:0]  s_data;
  logic         s_ready, is_new_weight, reset_pp, read_enable, busy, done, err_start;
  logic [255:0] weight_in0, weight_in1, weight_in2, weight_in3;
  logic [6:0]   rows_loaded;
  logic [31:0]  checksum;

  int   vectors = 0;
  int   fails   = 0;
  logic tog_exp;
  int   rows_exp;
  logic [31:0] csum_exp;
  int   w;

  fp_weight_loader dut (
    .clk          (clk),
    .reset        (reset),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .s_data       (s_data),
    .start        (start),
    .reload       (reload),
    .weight_in0   (weight_in0),
    .weight_in1   (weight_in1),
    .weight_in2   (weight_in2),
    .weight_in3   (weight_in3),
    .is_new_weight(is_new_weight),
    .reset_pp     (reset_pp),
    .read_enable  (read_enable),
    .rows_loaded  (rows_loaded),
    .busy         (busy),
    .done         (done),
    .err_start    (err_start),
    .checksum     (checksum)
  );

  always #5 clk = ~clk;

  // Weight buffer: write on each strobe edge, read on read_enable, address wraps.
  logic [1023:0] mem [64];
  logic [5:0]    wptr, rptr;
  logic          last_tog;
  logic [1023:0] rd_q [$];

  always @(posedge clk) begin
    if (reset) begin
      wptr     <= '0;
      rptr     <= '0;
      last_tog <= 1'b0;
    end else begin
      if (is_new_weight != last_tog) begin
        mem[wptr] <= {weight_in3, weight_in2, weight_in1, weight_in0};
        wptr      <= wptr + 6'd1;
      end
      last_tog <= is_new_weight;
      if (read_enable) begin
        rd_q.push_back(mem[rptr]);
        rptr <= rptr + 6'd1;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    s_valid = 1'b0;
    start   = 1'b0;
    reload  = 1'b0;
    s_data  = '0;
    tick();
    tick();
    reset    = 1'b0;
    tog_exp  = 1'b0;
    rows_exp = 0;
  endtask

  task automatic send_beat(input logic [31:0] d);
    int n;
    s_valid = 1'b1;
    s_data  = d;
    n = 0;
    while (!s_ready && n < 8) begin
      tick();
      n++;
    end
    chk("beat_ready", 32'(s_ready), 32'd1);
    tick();
  endtask

  task automatic send_row(input int r);
    for (int k = 0; k < 32; k++) send_beat(32'(r * 32 + k + 1));
    tog_exp = ~tog_exp;
    rows_exp++;
    chk("row_toggle", 32'(is_new_weight), 32'(tog_exp));
    chk("row_gap", 32'(s_ready), 32'd0);
    chk("row_count", 32'(rows_loaded), 32'(rows_exp));
    chk("row_busy", 32'(busy), 32'd1);
    chk("lane0_lo", weight_in0[31:0], 32'(r * 32 + 1));
    chk("lane3_hi", weight_in3[255:224], 32'(r * 32 + 32));
    tick();
    chk("row_resume", 32'(s_ready), 32'(rows_exp != 64));
  endtask

  initial begin
    do_reset();
    chk("rst_ready", 32'(s_ready), 32'd1);
    chk("rst_toggle", 32'(is_new_weight), 32'd0);
    chk("rst_rows", 32'(rows_loaded), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_pp", 32'(reset_pp), 32'd0);
    chk("rst_re", 32'(read_enable), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err_start), 32'd0);
    chk("rst_csum", checksum, 32'd0);
    chk("rst_lane", weight_in0[31:0], 32'd0);

    // Fill all 64 rows back-to-back with s_valid held high.
    for (int r = 0; r < 64; r++) send_row(r);
    chk("full_rows", 32'(rows_loaded), 32'd64);
    chk("full_ready", 32'(s_ready), 32'd0);
    chk("full_busy", 32'(busy), 32'd0);
    s_data = 32'hDEAD_BEEF;
    repeat (3) tick();
    chk("ign_rows", 32'(rows_loaded), 32'd64);
    chk("ign_toggle", 32'(is_new_weight), 32'(tog_exp));
    chk("ign_lane", weight_in0[31:0], 32'd2017);
    chk("ign_ready", 32'(s_ready), 32'd0);
    s_valid = 1'b0;

    // Read phase.
    rd_q.delete();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("prime_pp", 32'(reset_pp), 32'd1);
    chk("prime_re", 32'(read_enable), 32'd0);
    chk("prime_busy", 32'(busy), 32'd1);
    tick();
    for (int i = 0; i < 64; i++) begin
      chk("run_re", 32'(read_enable), 32'd1);
      chk("run_done", 32'(done), 32'd0);
      chk("run_pp", 32'(reset_pp), 32'd0);
      tick();
    end
    chk("end_done", 32'(done), 32'd1);
    chk("end_re", 32'(read_enable), 32'd0);
    chk("end_busy", 32'(busy), 32'd0);
    tick();
    chk("done_pulse", 32'(done), 32'd0);
    chk("rd_count", 32'(rd_q.size()), 32'd64);
    for (int i = 0; i < 64 && i < rd_q.size(); i++) begin
      chk("rd_row_lo", rd_q[i][31:0], 32'(i * 32 + 1));
      chk("rd_row_hi", rd_q[i][1023:992], 32'(i * 32 + 32));
    end

    // start and reload together: start wins, rows kept.
    start  = 1'b1;
    reload = 1'b1;
    tick();
    start  = 1'b0;
    reload = 1'b0;
    chk("both_pp", 32'(reset_pp), 32'd1);
    chk("both_rows", 32'(rows_loaded), 32'd64);
    w = 0;
    while (!done && w < 100) begin
      tick();
      w++;
    end
    chk("both_done", 32'(done), 32'd1);
    tick();

    // reload, then start outside LOADED.
    reload = 1'b1;
    tick();
    reload = 1'b0;
    chk("reload_ready", 32'(s_ready), 32'd1);
    chk("reload_rows", 32'(rows_loaded), 32'd0);
    rows_exp = 0;
    for (int r = 0; r < 5; r++) send_row(r);
    s_valid = 1'b0;
    reload  = 1'b1;
    tick();
    reload = 1'b0;
    chk("reload_ign", 32'(rows_loaded), 32'd5);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("err_pulse", 32'(err_start), 32'd1);
    chk("err_pp", 32'(reset_pp), 32'd0);
    chk("err_re", 32'(read_enable), 32'd0);
    chk("err_ready", 32'(s_ready), 32'd1);
    tick();
    chk("err_clear", 32'(err_start), 32'd0);
    chk("err_pp2", 32'(reset_pp), 32'd0);
    chk("err_re2", 32'(read_enable), 32'd0);

    // Reset in the middle of row 3.
    do_reset();
    for (int r = 0; r < 3; r++) send_row(r);
    for (int k = 0; k < 12; k++) send_beat(32'(3 * 32 + k + 1));
    s_data  = 32'(3 * 32 + 13);
    reset   = 1'b1;
    tick();
    s_valid = 1'b0;
    reset   = 1'b0;
    tog_exp  = 1'b0;
    rows_exp = 0;
    chk("mid_rows", 32'(rows_loaded), 32'd0);
    chk("mid_toggle", 32'(is_new_weight), 32'd0);
    chk("mid_ready", 32'(s_ready), 32'd1);
    chk("mid_busy", 32'(busy), 32'd0);
    chk("mid_lane", weight_in0[31:0], 32'd0);
    send_row(0);
    s_valid = 1'b0;
    chk("mid_new_rows", 32'(rows_loaded), 32'd1);

    // Checksum and partial-row hold.
    do_reset();
    send_beat(32'hA5A5_A5A5);
    send_beat(32'h0F0F_0F0F);
    s_valid = 1'b0;
    repeat (4) tick();
`ifdef FP_WLOAD_CHECKSUM_EN
    csum_exp = 32'hAAAA_AAAA;
`else
    csum_exp = 32'h0;
`endif
    chk("csum", checksum, csum_exp);
    chk("part_rows", 32'(rows_loaded), 32'd0);
    chk("part_ready", 32'(s_ready), 32'd1);
    chk("part_b0", weight_in0[31:0], 32'hA5A5_A5A5);
    chk("part_b1", weight_in0[63:32], 32'h0F0F_0F0F);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
